// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order commit queue between issue and the register
// file. Entries are allocated at issue, filled out of order from the CDB, and
// retired one per cycle in program order.
module reorder_buffer #(
   parameter int WORD_SIZE = 32,
   parameter int RB_INDEX  = 3,
   parameter int REG_INDEX = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 issue_req,
   input  logic [REG_INDEX-1:0] issue_reg,
   output logic                 issue_ok,
   output logic [RB_INDEX-1:0]  issue_index,
   input  logic                 cdb_valid,
   input  logic [RB_INDEX-1:0]  cdb_index,
   input  logic [WORD_SIZE-1:0] cdb_value,
   input  logic [RB_INDEX-1:0]  query_j,
   input  logic [RB_INDEX-1:0]  query_k,
   output logic                 query_j_ready,
   output logic                 query_k_ready,
   output logic [WORD_SIZE-1:0] query_j_value,
   output logic [WORD_SIZE-1:0] query_k_value,
   output logic                 commit_valid,
   output logic [REG_INDEX-1:0] commit_reg,
   output logic [WORD_SIZE-1:0] commit_value,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 2 ** RB_INDEX;
   localparam int CW    = RB_INDEX + 1;

   // Per-entry control
   logic [DEPTH-1:0]     busy_q, busy_d;
   logic [DEPTH-1:0]     ready_q, ready_d;
   // Per-entry payload (not reset: only meaningful while busy)
   logic [REG_INDEX-1:0] dest_q  [DEPTH];
   logic [REG_INDEX-1:0] dest_d  [DEPTH];
   logic [WORD_SIZE-1:0] value_q [DEPTH];
   logic [WORD_SIZE-1:0] value_d [DEPTH];
   // Global pointers and occupancy
   logic [RB_INDEX-1:0]  head_q, head_d;
   logic [RB_INDEX-1:0]  tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   // Registered commit port
   logic                 commit_valid_q, commit_valid_d;
   logic [REG_INDEX-1:0] commit_reg_q, commit_reg_d;
   logic [WORD_SIZE-1:0] commit_value_q, commit_value_d;

   logic issue_fire;
   logic commit_fire;
   logic cdb_fire;
   logic cdb_hit_j;
   logic cdb_hit_k;

   // Occupancy flags, acceptance and retirement decisions, all from pre-edge state
   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign issue_fire  = issue_req & ~full & ~flush;
   assign issue_ok    = issue_fire;
   assign issue_index = tail_q;
   // Head retires only on data already stored, so a CDB write to head waits one cycle
   assign commit_fire = busy_q[head_q] & ready_q[head_q];
   // The entry being issued this cycle is not busy yet, so a CDB write to it drops out here
   assign cdb_fire    = cdb_valid & busy_q[cdb_index] & ~ready_q[cdb_index];

   // Operand lookup with CDB bypass; non-busy entries always read as not ready, zero
   assign cdb_hit_j     = cdb_valid & (cdb_index == query_j);
   assign cdb_hit_k     = cdb_valid & (cdb_index == query_k);
   assign query_j_ready = busy_q[query_j] & (ready_q[query_j] | cdb_hit_j);
   assign query_k_ready = busy_q[query_k] & (ready_q[query_k] | cdb_hit_k);
   assign query_j_value = ~busy_q[query_j] ? '0 :
                          ready_q[query_j] ? value_q[query_j] :
                          cdb_hit_j        ? cdb_value : '0;
   assign query_k_value = ~busy_q[query_k] ? '0 :
                          ready_q[query_k] ? value_q[query_k] :
                          cdb_hit_k        ? cdb_value : '0;

   assign commit_valid = commit_valid_q;
   assign commit_reg   = commit_reg_q;
   assign commit_value = commit_value_q;

   // Next-state: flush squashes everything, otherwise CDB write, commit and issue combine
   always_comb begin
      busy_d         = busy_q;
      ready_d        = ready_q;
      dest_d         = dest_q;
      value_d        = value_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_reg_d   = commit_reg_q;
      commit_value_d = commit_value_q;
      if (flush) begin
         busy_d         = '0;
         ready_d        = '0;
         head_d         = '0;
         tail_d         = '0;
         count_d        = '0;
         commit_reg_d   = '0;
         commit_value_d = '0;
      end else begin
         if (cdb_fire) begin
            value_d[cdb_index] = cdb_value;
            ready_d[cdb_index] = 1'b1;
         end
         if (commit_fire) begin
            commit_valid_d  = 1'b1;
            commit_reg_d    = dest_q[head_q];
            commit_value_d  = value_q[head_q];
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + RB_INDEX'(1);
         end
         if (issue_fire) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            dest_d[tail_q]  = issue_reg;
            tail_d          = tail_q + RB_INDEX'(1);
         end
         count_d = count_q + CW'(issue_fire) - CW'(commit_fire);
      end
   end

   // Control and commit-port registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q         <= '0;
         ready_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_reg_q   <= '0;
         commit_value_q <= '0;
      end else begin
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_reg_q   <= commit_reg_d;
         commit_value_q <= commit_value_d;
      end
   end

   // Entry payload storage, qualified by busy/ready so it needs no reset
   always_ff @(posedge clk) begin
      dest_q  <= dest_d;
      value_q <= value_d;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scoreboard of expected commits in
// program order, one task per scenario.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        reset, flush, issue_req, cdb_valid;
   logic [4:0]  issue_reg;
   logic [2:0]  cdb_index, query_j, query_k, issue_index;
   logic [31:0] cdb_value, query_j_value, query_k_value, commit_value;
   logic        issue_ok, query_j_ready, query_k_ready, commit_valid, full, empty;
   logic [4:0]  commit_reg;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] v;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   reorder_buffer #(.WORD_SIZE(32), .RB_INDEX(3), .REG_INDEX(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .issue_req(issue_req), .issue_reg(issue_reg),
      .issue_ok(issue_ok), .issue_index(issue_index),
      .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_value(cdb_value),
      .query_j(query_j), .query_k(query_k),
      .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
      .query_j_value(query_j_value), .query_k_value(query_k_value),
      .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_value(commit_value),
      .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int r, input logic [31:0] v);
      exp_t e;
      e.r = 5'(r);
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; issue_req = 1'b0; cdb_valid = 1'b0;
      step();
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; issue_req = 1'b0; issue_reg = '0;
      cdb_valid = 1'b0; cdb_index = '0; cdb_value = '0; query_j = '0; query_k = '0;
      step(); step();
      reset = 1'b0;
      #1;
      total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
      total_cnt++; if (commit_valid !== 1'b0) $display("FAIL reset_commit_valid: got %b want 0", commit_valid); else pass_cnt++;
      total_cnt++; if (commit_reg !== 5'd0 || commit_value !== 32'd0)
         $display("FAIL reset_commit_fields: got r%0d/%h want r0/0", commit_reg, commit_value); else pass_cnt++;
      total_cnt++; if (issue_index !== 3'd0) $display("FAIL reset_issue_index: got %0d want 0", issue_index); else pass_cnt++;
   endtask

   task automatic test_issue();
      for (int i = 0; i < 3; i++) begin
         issue_req = 1'b1;
         issue_reg = 5'(i + 1);
         if (i == 2) begin
            cdb_valid = 1'b1; cdb_index = 3'd2; cdb_value = 32'hDEAD;
         end
         #1;
         total_cnt++; if (issue_ok !== 1'b1) $display("FAIL issue_ok[%0d]: got %b want 1", i, issue_ok); else pass_cnt++;
         total_cnt++; if (issue_index !== 3'(i)) $display("FAIL issue_index[%0d]: got %0d want %0d", i, issue_index, i); else pass_cnt++;
         push_exp(i + 1, 32'h11 * (i + 1));
         step();
         issue_req = 1'b0; cdb_valid = 1'b0;
         total_cnt++; if (commit_valid !== 1'b0) $display("FAIL issue_no_commit[%0d]: got %b want 0", i, commit_valid); else pass_cnt++;
      end
      query_j = 3'd2;
      #1;
      total_cnt++; if (empty !== 1'b0 || full !== 1'b0) $display("FAIL issue_flags: got empty=%b full=%b want 0/0", empty, full); else pass_cnt++;
      total_cnt++; if (query_j_ready !== 1'b0) $display("FAIL issue_same_cycle_cdb: got ready=%b want 0", query_j_ready); else pass_cnt++;
      step();
      total_cnt++; if (commit_valid !== 1'b0) $display("FAIL issue_pending: got %b want 0", commit_valid); else pass_cnt++;
   endtask

   task automatic test_out_of_order();
      exp_t e;
      cdb_valid = 1'b1; cdb_index = 3'd2; cdb_value = 32'h33;
      step();
      total_cnt++; if (commit_valid !== 1'b0) $display("FAIL ooo_after_idx2: got %b want 0", commit_valid); else pass_cnt++;
      cdb_index = 3'd0; cdb_value = 32'h11;
      step();
      total_cnt++; if (commit_valid !== 1'b0) $display("FAIL ooo_after_idx0: got %b want 0", commit_valid); else pass_cnt++;
      cdb_index = 3'd1; cdb_value = 32'h22;
      step();
      cdb_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) step();
         total_cnt++;
         if (commit_valid !== 1'b1) $display("FAIL ooo_commit_valid[%0d]: got %b want 1", c, commit_valid);
         else if (sb.size() == 0) $display("FAIL ooo_commit[%0d]: got r%0d/%h want nothing queued", c, commit_reg, commit_value);
         else begin
            e = sb.pop_front();
            if (commit_reg !== e.r || commit_value !== e.v)
               $display("FAIL ooo_commit[%0d]: got r%0d/%h want r%0d/%h", c, commit_reg, commit_value, e.r, e.v);
            else pass_cnt++;
         end
      end
      step();
      total_cnt++; if (commit_valid !== 1'b0 || empty !== 1'b1)
         $display("FAIL ooo_drained: got valid=%b empty=%b want 0/1", commit_valid, empty); else pass_cnt++;
      total_cnt++; if (commit_reg !== 5'd3 || commit_value !== 32'h33)
         $display("FAIL ooo_hold: got r%0d/%h want r3/33", commit_reg, commit_value); else pass_cnt++;
   endtask

   task automatic test_full();
      exp_t e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         issue_req = 1'b1; issue_reg = 5'(8 + i);
         #1;
         total_cnt++; if (issue_ok !== 1'b1) $display("FAIL fill_ok[%0d]: got %b want 1", i, issue_ok); else pass_cnt++;
         push_exp(8 + i, 32'h100 + i);
         step();
      end
      issue_req = 1'b1; issue_reg = 5'd20;
      #1;
      total_cnt++; if (full !== 1'b1 || empty !== 1'b0) $display("FAIL full_flags: got full=%b empty=%b want 1/0", full, empty); else pass_cnt++;
      total_cnt++; if (issue_ok !== 1'b0) $display("FAIL full_reject: got %b want 0", issue_ok); else pass_cnt++;
      cdb_valid = 1'b1; cdb_index = 3'd0; cdb_value = 32'h100;
      step();
      cdb_valid = 1'b0;
      #1;
      total_cnt++; if (issue_ok !== 1'b0) $display("FAIL full_commit_cycle_reject: got %b want 0", issue_ok); else pass_cnt++;
      step();
      total_cnt++;
      if (commit_valid !== 1'b1) $display("FAIL full_commit_valid: got %b want 1", commit_valid);
      else if (sb.size() == 0) $display("FAIL full_commit: got r%0d/%h want nothing queued", commit_reg, commit_value);
      else begin
         e = sb.pop_front();
         if (commit_reg !== e.r || commit_value !== e.v)
            $display("FAIL full_commit: got r%0d/%h want r%0d/%h", commit_reg, commit_value, e.r, e.v);
         else pass_cnt++;
      end
      total_cnt++; if (issue_ok !== 1'b1 || issue_index !== 3'd0)
         $display("FAIL wrap_accept: got ok=%b idx=%0d want 1/0", issue_ok, issue_index); else pass_cnt++;
      push_exp(20, 32'h200);
      step();
      issue_req = 1'b0;
      #1;
      total_cnt++; if (full !== 1'b1) $display("FAIL refull: got %b want 1", full); else pass_cnt++;
   endtask

   task automatic test_lookup();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         issue_req = 1'b1; issue_reg = 5'(4 + i);
         push_exp(4 + i, 32'h40 + i);
         step();
      end
      issue_req = 1'b0;
      cdb_valid = 1'b1; cdb_index = 3'd1; cdb_value = 32'hABCD;
      query_j = 3'd1; query_k = 3'd5;
      #1;
      total_cnt++; if (query_j_ready !== 1'b1 || query_j_value !== 32'hABCD)
         $display("FAIL bypass_j: got %b/%h want 1/abcd", query_j_ready, query_j_value); else pass_cnt++;
      total_cnt++; if (query_k_ready !== 1'b0 || query_k_value !== 32'd0)
         $display("FAIL empty_k: got %b/%h want 0/0", query_k_ready, query_k_value); else pass_cnt++;
      step();
      cdb_valid = 1'b0; query_k = 3'd0;
      #1;
      total_cnt++; if (query_j_ready !== 1'b1 || query_j_value !== 32'hABCD)
         $display("FAIL stored_j: got %b/%h want 1/abcd", query_j_ready, query_j_value); else pass_cnt++;
      total_cnt++; if (query_k_ready !== 1'b0 || query_k_value !== 32'd0)
         $display("FAIL pending_k: got %b/%h want 0/0", query_k_ready, query_k_value); else pass_cnt++;
      total_cnt++; if (commit_valid !== 1'b0) $display("FAIL lookup_no_commit: got %b want 0", commit_valid); else pass_cnt++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         issue_req = 1'b1; issue_reg = 5'(10 + i);
         push_exp(10 + i, 32'h50 + i);
         step();
      end
      flush = 1'b1; issue_req = 1'b1; issue_reg = 5'd30;
      cdb_valid = 1'b1; cdb_index = 3'd0; cdb_value = 32'h55;
      #1;
      total_cnt++; if (issue_ok !== 1'b0) $display("FAIL flush_issue_ok: got %b want 0", issue_ok); else pass_cnt++;
      step();
      flush = 1'b0; issue_req = 1'b0; cdb_valid = 1'b0;
      sb.delete();
      #1;
      total_cnt++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL flush_flags: got empty=%b full=%b want 1/0", empty, full); else pass_cnt++;
      total_cnt++; if (commit_valid !== 1'b0) $display("FAIL flush_commit_valid: got %b want 0", commit_valid); else pass_cnt++;
      total_cnt++; if (issue_index !== 3'd0) $display("FAIL flush_issue_index: got %0d want 0", issue_index); else pass_cnt++;
      cdb_valid = 1'b1; cdb_index = 3'd0; cdb_value = 32'h77; query_j = 3'd0;
      #1;
      total_cnt++; if (query_j_ready !== 1'b0) $display("FAIL flush_lookup: got %b want 0", query_j_ready); else pass_cnt++;
      step();
      cdb_valid = 1'b0;
      step();
      total_cnt++; if (commit_valid !== 1'b0 || empty !== 1'b1)
         $display("FAIL flush_stale: got valid=%b empty=%b want 0/1", commit_valid, empty); else pass_cnt++;
   endtask

   task automatic test_reset_mid_commit();
      exp_t e;
      int regs [3];
      regs = '{0, 6, 7};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue_req = 1'b1; issue_reg = 5'(regs[i]);
         push_exp(regs[i], 32'h60 + i);
         step();
      end
      issue_req = 1'b0;
      cdb_valid = 1'b1; cdb_index = 3'd0; cdb_value = 32'h60;
      step();
      cdb_index = 3'd1; cdb_value = 32'h61;
      step();
      total_cnt++;
      if (commit_valid !== 1'b1) $display("FAIL r0_commit_valid: got %b want 1", commit_valid);
      else if (sb.size() == 0) $display("FAIL r0_commit: got r%0d/%h want nothing queued", commit_reg, commit_value);
      else begin
         e = sb.pop_front();
         if (commit_reg !== e.r || commit_value !== e.v)
            $display("FAIL r0_commit: got r%0d/%h want r%0d/%h", commit_reg, commit_value, e.r, e.v);
         else pass_cnt++;
      end
      reset = 1'b1; cdb_index = 3'd2; cdb_value = 32'h62;
      step();
      reset = 1'b0; cdb_valid = 1'b0;
      sb.delete();
      total_cnt++; if (commit_valid !== 1'b0 || commit_reg !== 5'd0 || commit_value !== 32'd0)
         $display("FAIL midreset_commit: got %b r%0d/%h want 0 r0/0", commit_valid, commit_reg, commit_value); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1 || issue_index !== 3'd0)
         $display("FAIL midreset_state: got empty=%b idx=%0d want 1/0", empty, issue_index); else pass_cnt++;
      cdb_valid = 1'b1; cdb_index = 3'd1; cdb_value = 32'h99; query_j = 3'd1;
      #1;
      total_cnt++; if (query_j_ready !== 1'b0 || query_j_value !== 32'd0)
         $display("FAIL midreset_lookup: got %b/%h want 0/0", query_j_ready, query_j_value); else pass_cnt++;
      step();
      cdb_valid = 1'b0;
      step();
      total_cnt++; if (commit_valid !== 1'b0 || empty !== 1'b1)
         $display("FAIL midreset_stale: got valid=%b empty=%b want 0/1", commit_valid, empty); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_issue();
      test_out_of_order();
      test_full();
      test_lookup();
      test_flush();
      test_reset_mid_commit();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer sitting between the issue stage and the register file.
- Allocates an entry, and hands out its RB_index, for every issued instruction.
- Receives out-of-order results from the ALU reservation stations over the common data bus (CDB), and retires them in program order.
- Serves operand lookups so issue can fill the vj/vk or qj/qk fields of a reservation station.

Parameters:
- WORD_SIZE, 32, data word width
- RB_INDEX, 3, entry index width; depth = 2**RB_INDEX (8)
- REG_INDEX, 5, architectural register index width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- flush  input  1  synchronous squash of all entries (mispredict/exception)
- issue_req  input  1  issue stage requests allocation this cycle
- issue_reg  input  REG_INDEX  destination register of issuing instruction
- issue_ok  output  1  combinational: allocation accepted (issue_req & !full & !flush)
- issue_index  output  RB_INDEX  combinational: tail pointer, index given to the new entry
- cdb_valid  input  1  result broadcast valid
- cdb_index  input  RB_INDEX  entry the result belongs to (the RS's RB_index)
- cdb_value  input  WORD_SIZE  result word
- query_j, query_k  input  RB_INDEX  entries being looked up for operand j/k
- query_j_ready, query_k_ready  output  1  combinational: entry holds its result (incl. CDB bypass)
- query_j_value, query_k_value  output  WORD_SIZE  combinational: that result, 0 if not ready
- commit_valid  output  1  registered: one entry retired last edge
- commit_reg  output  REG_INDEX  registered: its destination register
- commit_value  output  WORD_SIZE  registered: its result
- full, empty  output  1  combinational from count

Behaviour:
- Per-entry state: busy, ready, dest[REG_INDEX], value[WORD_SIZE]. Global state: head, tail (RB_INDEX bits, natural wrap), count (RB_INDEX+1 bits).
- full = (count == 2**RB_INDEX); empty = (count == 0).
- Reset (or flush) at an edge:
  - all busy/ready <= 0; head = tail = count <= 0
  - commit_valid <= 0; commit_reg <= 0; commit_value <= 0
  - flush has priority over issue, CDB write and commit in the same cycle.
- Issue:
  - If issue_ok at the edge: entry[tail] <= {busy=1, ready=0, dest=issue_reg}; tail <= tail+1.
  - full is evaluated from pre-edge count, so a simultaneous commit does not free a slot for an issue in the same cycle.
- CDB write:
  - If cdb_valid and entry[cdb_index].busy and !ready: value <= cdb_value, ready <= 1.
  - A write to a non-busy or already-ready entry is ignored.
  - A write to the entry being issued in the same cycle is ignored, since the entry is not yet busy.
- Commit:
  - If entry[head].busy and entry[head].ready at the edge: commit_valid <= 1, commit_reg/commit_value <= entry fields; entry[head].busy <= 0; head <= head+1.
  - Otherwise commit_valid <= 0; commit_reg/commit_value hold their values.
  - At most one commit per cycle.
  - A CDB write to head in cycle N commits at the edge ending cycle N+1 (no same-cycle commit of incoming data).
  - Latency from issue to earliest commit_valid = 2 edges.
- Count update: count <= count + issue_accepted - committed (both may occur in one cycle, net 0).
- Lookup:
  - ready = busy & ready, or (cdb_valid & cdb_index == query & busy). The CDB bypass supplies cdb_value.
  - A non-busy entry returns ready=0, value=0.
- Destination register 0 is committed normally; the register file ignores writes to r0.
- Pointer wrap: index 7 + 1 = 0; no special casing.

Test Plan:
- Reset, then issue 3 entries (regs 1,2,3):
  - issue_index reads 0,1,2; count=3; empty=0.
  - No commit while results are pending.
- Out-of-order completion, with entries 0,1,2 issued:
  - CDB writes index 2 = 0x33, then index 0 = 0x11, then index 1 = 0x22.
  - Commits appear in order: (r1,0x11), (r2,0x22), (r3,0x33) on consecutive cycles after the index-1 write.
- Fill 8 entries:
  - full=1, issue_ok=0 for a 9th request.
  - Complete head; in the cycle of the commit edge a request is still rejected; it is accepted the next cycle with issue_index=0 (wrap).
- Lookup with CDB bypass:
  - query_j=1 while cdb_valid, cdb_index=1, cdb_value=0xABCD -> query_j_ready=1, value=0xABCD in the same cycle.
  - query_k of an empty entry -> ready=0, value=0.
- Flush with 5 entries busy and a simultaneous issue and CDB write:
  - Next cycle empty=1, count=0, commit_valid=0, issue_index=0.
- Reset asserted mid-commit stream:
  - commit_valid=0 next cycle, all outputs 0, stale CDB writes to old indices ignored.
